// File: rtl/lcd8080_stream_controller.sv
// rtl/lcd8080_stream_controller.sv - write-only 8080 LCD bus engine with input FIFO and hardware fill
//
// Buffers {is_cmd, data} words and plays them onto an 8080-style panel bus.
// Each beat is SETUP (1 cycle) + WR_LO (WR_LOW_CYC) + WR_HI (WR_HIGH_CYC).
// Chip select stays low across back-to-back beats. A fill request repeats one
// pixel fill_count times once the FIFO has drained.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            input word handshake
//   in_is_cmd, in_data           word type (1 = command) and value
//   fill_start, fill_pixel,      fill request, sampled together, honoured
//   fill_count                   only while busy is low
//   busy, fifo_level             activity flag and FIFO occupancy
//   data_bus, lcd_rs, lcd_wr,    registered panel pins (strobes active low)
//   lcd_rd, lcd_cs
module lcd8080_stream_controller #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int CNT_W       = 24
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_is_cmd,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            fill_start,
    input  logic [DATA_W-1:0]               fill_pixel,
    input  logic [CNT_W-1:0]                fill_count,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic [DATA_W-1:0]               data_bus,
    output logic                            lcd_rs,
    output logic                            lcd_wr,
    output logic                            lcd_rd,
    output logic                            lcd_cs
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = $clog2(FIFO_DEPTH + 1);
    localparam int TMAX = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, WR_LO, WR_HI} state_t;

    state_t            state;
    logic [TW-1:0]     tcnt;
    logic [CNT_W-1:0]  fill_remaining;
    logic [DATA_W-1:0] fill_pixel_r;
    logic              fill_active;
    logic              beat_is_fill;

    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic [DATA_W:0]   fifo_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic hi_last;
    logic start_fill;

    assign full     = (level == LW'(FIFO_DEPTH));
    assign empty    = (level == '0);
    // in_ready is gated by rst so nothing can be pushed into a FIFO being flushed.
    assign in_ready = !rst && !full && !fill_active;
    assign push     = in_valid && in_ready;
    assign fifo_q   = mem[rd_ptr];

    // A new beat may only be launched from IDLE or on the final WR_HI cycle;
    // FIFO words take priority over fill beats.
    assign hi_last    = (state == WR_HI) && (tcnt == TW'(WR_HIGH_CYC - 1));
    assign pop        = !empty && ((state == IDLE) || hi_last);
    assign start_fill = empty && (fill_remaining != '0) && ((state == IDLE) || hi_last);

    assign busy       = (state != IDLE) || !empty || (fill_remaining != '0);
    assign fifo_level = level;
    assign lcd_rd     = 1'b1;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_is_cmd, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            tcnt           <= '0;
            fill_remaining <= '0;
            fill_pixel_r   <= '0;
            fill_active    <= 1'b0;
            beat_is_fill   <= 1'b0;
            data_bus       <= '0;
            lcd_rs         <= 1'b1;
            lcd_wr         <= 1'b1;
            lcd_cs         <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // busy low means nothing is queued, so the fill cannot race a beat start.
                    if (fill_start && !busy && (fill_count != '0)) begin
                        fill_remaining <= fill_count;
                        fill_pixel_r   <= fill_pixel;
                        fill_active    <= 1'b1;
                    end
                end
                SETUP: begin
                    lcd_wr <= 1'b0;
                    tcnt   <= '0;
                    state  <= WR_LO;
                end
                WR_LO: begin
                    if (tcnt == TW'(WR_LOW_CYC - 1)) begin
                        lcd_wr <= 1'b1;
                        tcnt   <= '0;
                        state  <= WR_HI;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                WR_HI: begin
                    if (!hi_last) begin
                        tcnt <= tcnt + TW'(1);
                    end else begin
                        if (beat_is_fill && (fill_remaining == '0)) begin
                            fill_active <= 1'b0;
                        end
                        if (!pop && !start_fill) begin
                            state  <= IDLE;
                            lcd_cs <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Beat launch overrides the per-state next-state above.
            if (pop) begin
                data_bus     <= fifo_q[DATA_W-1:0];
                lcd_rs       <= ~fifo_q[DATA_W];
                lcd_cs       <= 1'b0;
                beat_is_fill <= 1'b0;
                state        <= SETUP;
            end else if (start_fill) begin
                data_bus       <= fill_pixel_r;
                lcd_rs         <= 1'b1;
                lcd_cs         <= 1'b0;
                beat_is_fill   <= 1'b1;
                fill_remaining <= fill_remaining - CNT_W'(1);
                state          <= SETUP;
            end
        end
    end

endmodule

// File: tb/tb_lcd8080_stream_controller.sv
// tb/tb_lcd8080_stream_controller.sv - scoreboard bench for lcd8080_stream_controller
module tb_lcd8080_stream_controller;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 24;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_is_cmd = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          fill_start = 1'b0;
    logic [DW-1:0] fill_pixel = '0;
    logic [CW-1:0] fill_count = '0;
    logic          busy;
    logic [LW-1:0] fifo_level;
    logic [DW-1:0] data_bus;
    logic          lcd_rs;
    logic          lcd_wr;
    logic          lcd_rd;
    logic          lcd_cs;

    lcd8080_stream_controller #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .WR_LOW_CYC(2), .WR_HIGH_CYC(2), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_cmd(in_is_cmd), .in_data(in_data), .fill_start(fill_start),
        .fill_pixel(fill_pixel), .fill_count(fill_count), .busy(busy),
        .fifo_level(fifo_level), .data_bus(data_bus), .lcd_rs(lcd_rs),
        .lcd_wr(lcd_wr), .lcd_rd(lcd_rd), .lcd_cs(lcd_cs)
    );

    always #5 clk = ~clk;

    logic [DW:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int wr_rise_cnt = 0;
    int wr_low_cnt = 0;
    int cs_low_cnt = 0;
    int cs_rise_cnt = 0;
    logic mon_prev_wr = 1'b1;
    logic mon_prev_cs = 1'b1;

    // Beat monitor: the panel latches on the lcd_wr rising edge, so each rise pops the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (mon_prev_wr === 1'b0 && lcd_wr === 1'b1) begin
                wr_rise_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_unexpected got rs=%b data=%h required no beat", lcd_rs, data_bus);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    if ({lcd_rs, data_bus} !== e) begin
                        failures++;
                        $display("FAIL beat_value got rs=%b data=%h required rs=%b data=%h",
                                 lcd_rs, data_bus, e[DW], e[DW-1:0]);
                    end
                end
            end
            if (lcd_wr === 1'b0) wr_low_cnt++;
            if (lcd_cs === 1'b0) cs_low_cnt++;
            if (mon_prev_cs === 1'b0 && lcd_cs === 1'b1) cs_rise_cnt++;
        end
        mon_prev_wr = lcd_wr;
        mon_prev_cs = lcd_cs;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        wr_rise_cnt = 0;
        wr_low_cnt  = 0;
        cs_low_cnt  = 0;
        cs_rise_cnt = 0;
    endtask

    task automatic push_word(input logic cmd, input logic [DW-1:0] d);
        int n;
        in_valid  = 1'b1;
        in_is_cmd = cmd;
        in_data   = d;
        n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout in_ready=%b required 1", in_ready);
        end else begin
            exp_q.push_back({~cmd, d});
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_timeout busy=%b required 0", name, busy);
        end
    endtask

    task automatic check_reset_pins(input string name);
        checks++;
        if ({data_bus, lcd_rs, lcd_wr, lcd_rd, lcd_cs} !== {16'h0000, 4'b1111}) begin
            failures++;
            $display("FAIL %s_pins got data=%h rs=%b wr=%b rd=%b cs=%b required 0000 1 1 1 1",
                     name, data_bus, lcd_rs, lcd_wr, lcd_rd, lcd_cs);
        end
        checks++;
        if (fifo_level !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_state got level=%0d busy=%b required 0 0", name, fifo_level, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        check_reset_pins("reset");
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready_during got %b required 0", in_ready);
        end
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready_after got %b required 1", in_ready);
        end
        check_reset_pins("reset_after");
    endtask

    task automatic test_single_command();
        logic prev_cs;
        clear_counters();
        push_word(1'b1, 16'h0022);
        prev_cs = lcd_cs;
        repeat (12) begin
            step();
            if (prev_cs === 1'b0 && lcd_cs === 1'b1) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL single_busy_fall got busy=%b required 0 when cs rises", busy);
                end
            end
            prev_cs = lcd_cs;
        end
        checks++;
        if (cs_low_cnt != 5 || wr_low_cnt != 2 || wr_rise_cnt != 1) begin
            failures++;
            $display("FAIL single_timing got cs_low=%0d wr_low=%0d beats=%0d required 5 2 1",
                     cs_low_cnt, wr_low_cnt, wr_rise_cnt);
        end
    endtask

    task automatic test_burst();
        clear_counters();
        push_word(1'b1, 16'h0022);
        push_word(1'b0, 16'h1234);
        push_word(1'b0, 16'hABCD);
        wait_idle(100, "burst");
        step();
        checks++;
        if (cs_low_cnt != 15 || cs_rise_cnt != 1 || wr_rise_cnt != 3 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL burst_timing got cs_low=%0d cs_rises=%0d beats=%0d left=%0d required 15 1 3 0",
                     cs_low_cnt, cs_rise_cnt, wr_rise_cnt, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit saw_full;
        int n;
        saw_full = 0;
        clear_counters();
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_is_cmd = (i == 0);
            in_data   = 16'h1000 + 16'(i * 16'h0111);
            n = 0;
            while (!in_ready && n < 100) begin
                checks++;
                if (fifo_level !== LW'(DEPTH)) begin
                    failures++;
                    $display("FAIL bp_ready_low got level=%0d required %0d", fifo_level, DEPTH);
                end
                saw_full = 1;
                step();
                n++;
            end
            checks++;
            if (!in_ready || fifo_level === LW'(DEPTH)) begin
                failures++;
                $display("FAIL bp_ready_high got in_ready=%b level=%0d required 1 below %0d",
                         in_ready, fifo_level, DEPTH);
            end else begin
                exp_q.push_back({~in_is_cmd, in_data});
            end
            step();
        end
        in_valid = 1'b0;
        wait_idle(300, "bp");
        checks++;
        if (!saw_full || wr_rise_cnt != 10 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_drain got saw_full=%0d beats=%0d left=%0d required 1 10 0",
                     saw_full, wr_rise_cnt, exp_q.size());
        end
    endtask

    task automatic test_fill();
        bit sent;
        int n;
        sent = 0;
        clear_counters();
        fill_pixel = 16'hF800;
        fill_count = 24'd4;
        fill_start = 1'b1;
        repeat (4) exp_q.push_back({1'b1, 16'hF800});
        step();
        fill_start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL fill_busy got %b required 1", busy);
        end
        n = 0;
        while (busy && n < 200) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL fill_in_ready got %b required 0", in_ready);
            end
            if (wr_rise_cnt == 2 && !sent) begin
                fill_pixel = 16'h1111;
                fill_count = 24'd5;
                fill_start = 1'b1;
                sent = 1;
                step();
                fill_start = 1'b0;
            end else begin
                step();
            end
            n++;
        end
        wait_idle(10, "fill");
        repeat (10) step();
        checks++;
        if (wr_rise_cnt != 4 || exp_q.size() != 0 || in_ready !== 1'b1 || !sent) begin
            failures++;
            $display("FAIL fill_count got beats=%0d left=%0d in_ready=%b sent=%0d required 4 0 1 1",
                     wr_rise_cnt, exp_q.size(), in_ready, sent);
        end
    endtask

    task automatic test_fill_zero();
        clear_counters();
        fill_pixel = 16'h5555;
        fill_count = '0;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL fill_zero_busy got %b required 0", busy);
        end
        repeat (10) step();
        checks++;
        if (wr_rise_cnt != 0 || cs_low_cnt != 0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL fill_zero_beats got beats=%0d cs_low=%0d in_ready=%b required 0 0 1",
                     wr_rise_cnt, cs_low_cnt, in_ready);
        end
    endtask

    task automatic test_reset_mid_burst();
        clear_counters();
        push_word(1'b1, 16'h002C);
        push_word(1'b0, 16'h0F0F);
        push_word(1'b0, 16'hF0F0);
        repeat (4) step();
        rst = 1'b1;
        exp_q.delete();
        step();
        check_reset_pins("rst_burst");
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_burst_in_ready got %b required 0", in_ready);
        end
        repeat (2) step();
        rst = 1'b0;
        clear_counters();
        step();
        check_reset_pins("rst_burst_after");
        repeat (20) step();
        checks++;
        if (wr_rise_cnt != 0 || cs_low_cnt != 0) begin
            failures++;
            $display("FAIL rst_burst_quiet got beats=%0d cs_low=%0d required 0 0", wr_rise_cnt, cs_low_cnt);
        end
    endtask

    task automatic test_reset_mid_fill();
        int n;
        clear_counters();
        fill_pixel = 16'h001F;
        fill_count = 24'd1000;
        fill_start = 1'b1;
        repeat (1000) exp_q.push_back({1'b1, 16'h001F});
        step();
        fill_start = 1'b0;
        n = 0;
        while (wr_rise_cnt < 10 && n < 500) begin
            step();
            n++;
        end
        checks++;
        if (wr_rise_cnt != 10) begin
            failures++;
            $display("FAIL rst_fill_progress got beats=%0d required 10", wr_rise_cnt);
        end
        rst = 1'b1;
        exp_q.delete();
        repeat (3) step();
        check_reset_pins("rst_fill");
        rst = 1'b0;
        clear_counters();
        repeat (30) step();
        checks++;
        if (wr_rise_cnt != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_fill_quiet got beats=%0d busy=%b required 0 0", wr_rise_cnt, busy);
        end
        fill_pixel = 16'h07E0;
        fill_count = 24'd3;
        fill_start = 1'b1;
        repeat (3) exp_q.push_back({1'b1, 16'h07E0});
        step();
        fill_start = 1'b0;
        wait_idle(100, "refill");
        repeat (5) step();
        checks++;
        if (wr_rise_cnt != 3 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL refill_count got beats=%0d left=%0d required 3 0", wr_rise_cnt, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_command();
        test_burst();
        test_backpressure();
        test_fill();
        test_fill_zero();
        test_reset_mid_burst();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd8080_stream_controller.md
# lcd8080_stream_controller

Parametrised write-only 8080-style parallel LCD bus engine, the successor to the fixed 16-bit HX8352 command/data path. It buffers a stream of command and data words in an internal FIFO and drives them onto the panel bus with configurable write-strobe timing, keeping chip-select asserted across back-to-back beats. A hardware fill mode repeats one pixel value N times without host traffic, for screen clears and rectangle fills. It sits between the display FSM or host logic and the panel pins; panel reset and delay sequencing stay outside.

## Interface
- DATA_W, 16: bus and word width (8 or 16).
- FIFO_DEPTH, 16: input FIFO entries; power of two, at least 2.
- WR_LOW_CYC, 2: cycles `lcd_wr` is held low per beat (at least 1).
- WR_HIGH_CYC, 2: cycles `lcd_wr` is held high after the low phase (at least 1).
- CNT_W, 24: width of the fill counter.

Ports:
- clk  in  1  single system clock.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  input word offered.
- in_ready  out  1  FIFO can accept; equals !full && !fill_active.
- in_is_cmd  in  1  1 = command word (rs=0), 0 = data word (rs=1).
- in_data  in  DATA_W  word to write.
- fill_start  in  1  single-cycle request to start a fill.
- fill_pixel  in  DATA_W  value repeated during the fill; sampled with fill_start.
- fill_count  in  CNT_W  number of fill beats; sampled with fill_start.
- busy  out  1  high when state != IDLE, the FIFO is non-empty, or fill_remaining != 0.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- data_bus  out  DATA_W  panel data pins.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_wr  out  1  active-low write strobe; the panel latches on the rising edge.
- lcd_rd  out  1  active-low read strobe; tied to 1.
- lcd_cs  out  1  active-low chip select.

## Operation
- FIFO push when in_valid && in_ready. Each entry is {is_cmd, data}, DATA_W+1 bits.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop and go to SETUP. Otherwise, if fill_remaining != 0, go to SETUP with the fill pixel and rs=1. Otherwise stay, with lcd_cs=1.
  - SETUP: lasts 1 cycle. lcd_cs=0, data_bus and lcd_rs are driven, lcd_wr=1.
  - WR_LO: lasts WR_LOW_CYC cycles with lcd_wr=0.
  - WR_HI: lasts WR_HIGH_CYC cycles with lcd_wr=1.
  - On the last WR_HI cycle, if another beat is available, go straight to SETUP with lcd_cs held 0. Otherwise go to IDLE and lcd_cs returns to 1.
- Beat priority: FIFO words go first. Fill beats issue only when the FIFO is empty. Since in_ready=0 while fill_active, the FIFO cannot refill mid-fill.
- Each fill beat decrements fill_remaining by 1.
- fill_start is accepted only when busy=0:
  - If fill_count=0, nothing happens and busy stays 0.
  - If busy=1, fill_start is ignored and no state changes.
- fill_active is high from the accepting edge until the last fill beat's WR_HI completes.
- data_bus and lcd_rs hold their last values in IDLE.
- All pin outputs are registered. lcd_rd is constant 1.

## Timing
- Reset values after any rst edge:
  - data_bus=0, lcd_rs=1, lcd_wr=1, lcd_rd=1, lcd_cs=1.
  - busy=0, fifo_level=0, FSM in IDLE.
  - FIFO flushed and fill_remaining=0.
  - in_ready=0 while rst is high, 1 on the first cycle after.
- Reset mid-beat aborts immediately. The next cycle shows the reset values; a truncated strobe is acceptable.
- Latency when idle and empty: word accepted at edge k, then lcd_cs=0 with data valid from edge k+1, lcd_wr=0 from edge k+2, rising edge of lcd_wr at edge k+2+WR_LOW_CYC.
- Beat period is exactly 1+WR_LOW_CYC+WR_HIGH_CYC cycles. A back-to-back stream has no idle gap.
- data_bus and lcd_rs are stable from SETUP through the end of WR_HI.
- Simultaneous push and pop at full: not possible, because in_ready=0 when full. The pop frees a slot on the following cycle.
- Simultaneous push and pop at any other level: fifo_level is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

## Test plan
- Reset: assert rst for 3 cycles mid-burst -> next cycle all pins at reset values, fifo_level=0, busy=0, no further lcd_wr edges.
- Single command, DATA_W=16, L=2, H=2: push 0x0022 with is_cmd=1 -> lcd_cs low exactly 5 cycles, lcd_rs=0, one lcd_wr low pulse of 2 cycles, data_bus=0x0022, busy falls on the cycle lcd_cs rises.
- Burst: push 0x22(cmd), 0x1234, 0xABCD on consecutive cycles -> lcd_cs low continuously for 15 cycles, rs sequence 0,1,1, data appears in push order.
- Backpressure, FIFO_DEPTH=4: hold in_valid for 10 words -> in_ready drops at fifo_level=4, all 10 words are written in order, none lost or duplicated.
- Fill: fill_start with pixel 0xF800, count 4 -> 4 beats with rs=1 and data 0xF800, in_ready=0 throughout. A second fill_start during the fill is ignored. count=0 produces no beats.
- Reset mid-fill, count 1000, rst at beat 10 -> no further beats after reset, and a new fill then runs exactly its requested count.
